// File: rtl/ps2_keyboard_fifo_if.sv
// ps2_keyboard_fifo_if
// Key-event read bus between the PS/2 keyboard receiver and its consumer
// (the ARM-side game logic).
//   RD_EN      consumer -> receiver  pop the head event
//   CODE       receiver -> consumer  scan code at the FIFO head
//   EXTENDED   receiver -> consumer  head event was prefixed by E0
//   BREAK      receiver -> consumer  head event was prefixed by F0
//   EMPTY      receiver -> consumer  no events stored
//   FULL       receiver -> consumer  FIFO_DEPTH events stored
//   COUNT      receiver -> consumer  number of stored events
//   KEY_PRESS  receiver -> consumer  one-cycle pulse on each stored key press
// The master modport is the receiver side, the slave modport the consumer.
interface ps2_keyboard_fifo_if #(
  parameter int FIFO_DEPTH = 8
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic             RD_EN;
  logic [7:0]       CODE;
  logic             EXTENDED;
  logic             BREAK;
  logic             EMPTY;
  logic             FULL;
  logic [CNT_W-1:0] COUNT;
  logic             KEY_PRESS;

  modport master (
    input  RD_EN,
    output CODE, EXTENDED, BREAK, EMPTY, FULL, COUNT, KEY_PRESS
  );

  modport slave (
    output RD_EN,
    input  CODE, EXTENDED, BREAK, EMPTY, FULL, COUNT, KEY_PRESS
  );
endinterface

// File: rtl/ps2_keyboard_fifo.sv
// ps2_keyboard_fifo
// PS/2 keyboard receiver: synchronises and glitch-filters the keyboard
// clock, receives 11-bit frames (start, 8 data LSB first, odd parity,
// stop), guards partial frames with a watchdog, decodes the E0/F0 prefix
// bytes and buffers key events in a show-ahead FIFO.
// Optional feature macro: PS2_BREAK_DECODE_EN. When defined, E0 and F0 are
// folded into the EXTENDED/BREAK flags of the following event; when
// undefined every good byte is stored as a plain event.
// Ports:
//   CLK, RST          system clock, synchronous active-high reset
//   PS2_CLK, PS2_DATA asynchronous keyboard lines
//   CLR_ERR           clears the sticky ERR and OVERFLOW flags
//   ev (master)       event read bus (see ps2_keyboard_fifo_if)
//   LAST_CODE         last good byte received, prefixes included
//   ERR               sticky frame error (start, parity or stop bit)
//   OVERFLOW          sticky flag: an event was dropped on a full FIFO
module ps2_keyboard_fifo #(
  parameter int FIFO_DEPTH     = 8,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       PS2_CLK,
  input  logic                       PS2_DATA,
  input  logic                       CLR_ERR,
  ps2_keyboard_fifo_if.master        ev,
  output logic [7:0]                 LAST_CODE,
  output logic                       ERR,
  output logic                       OVERFLOW
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int FLT_W = $clog2(FILTER_LEN + 1);
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;

  logic ps2_clk_s1_q, ps2_clk_s2_q, ps2_data_s1_q, ps2_data_s2_q;
  logic flt_q, flt_d;
  logic [FLT_W-1:0] flt_cnt_q, flt_cnt_d;
  logic strobe;

  rx_state_t state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic parity_q, parity_d;
  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic err_set, byte_good;

  logic push_req;
  logic [9:0] push_data;

  logic [9:0] mem_q [FIFO_DEPTH];
  logic [9:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic full, empty, do_push, do_pop, ovf_set;
  logic key_press_q, key_press_d;
  logic [7:0] last_code_q, last_code_d;
  logic err_q, err_d, ovf_q, ovf_d;
  logic [9:0] head;

  // The keyboard lines idle high, so the synchronisers reset to 1 to avoid
  // a spurious falling edge right after reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ps2_clk_s1_q  <= 1'b1;
      ps2_clk_s2_q  <= 1'b1;
      ps2_data_s1_q <= 1'b1;
      ps2_data_s2_q <= 1'b1;
    end else begin
      ps2_clk_s1_q  <= PS2_CLK;
      ps2_clk_s2_q  <= ps2_clk_s1_q;
      ps2_data_s1_q <= PS2_DATA;
      ps2_data_s2_q <= ps2_data_s1_q;
    end
  end

  // Glitch filter: the filtered clock follows the synchronised clock only
  // after FILTER_LEN consecutive samples disagree with it. Any agreeing
  // sample restarts the count, so short pulses never get through.
  always_comb begin
    flt_d     = flt_q;
    flt_cnt_d = '0;
    if (ps2_clk_s2_q != flt_q) begin
      if (flt_cnt_q == FLT_W'(FILTER_LEN - 1)) flt_d = ps2_clk_s2_q;
      else flt_cnt_d = flt_cnt_q + FLT_W'(1);
    end
  end

  assign strobe = flt_q & ~flt_d;

  // Frame receiver with watchdog. The watchdog only runs inside a frame
  // and is restarted by every strobe; on expiry the partial frame is
  // dropped without raising ERR, since a stalled keyboard is not a
  // corrupted byte.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    parity_d  = parity_q;
    wd_cnt_d  = '0;
    err_set   = 1'b0;
    byte_good = 1'b0;
    if (state_q != IDLE) wd_cnt_d = wd_cnt_q + WD_W'(1);
    if (strobe) begin
      wd_cnt_d = '0;
      case (state_q)
        IDLE: begin
          if (!ps2_data_s2_q) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end else begin
            err_set = 1'b1;
          end
        end
        DATA: begin
          shift_d   = {ps2_data_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          parity_d = ps2_data_s2_q;
          state_d  = STOP;
        end
        STOP: begin
          if ((^{shift_q, parity_q}) && ps2_data_s2_q) byte_good = 1'b1;
          else err_set = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE && wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
      state_d = IDLE;
    end
  end

`ifdef PS2_BREAK_DECODE_EN
  logic ext_q, ext_d, brk_q, brk_d;

  // Prefix bytes only arm the flags; the next ordinary byte carries them
  // into the FIFO and disarms them.
  always_comb begin
    ext_d     = ext_q;
    brk_d     = brk_q;
    push_req  = 1'b0;
    push_data = {ext_q, brk_q, shift_q};
    if (byte_good) begin
      if (shift_q == 8'hE0) ext_d = 1'b1;
      else if (shift_q == 8'hF0) brk_d = 1'b1;
      else begin
        push_req = 1'b1;
        ext_d    = 1'b0;
        brk_d    = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ext_q <= 1'b0;
      brk_q <= 1'b0;
    end else begin
      ext_q <= ext_d;
      brk_q <= brk_d;
    end
  end
`else
  assign push_req  = byte_good;
  assign push_data = {2'b00, shift_q};
`endif

  // Event FIFO. A pop frees the head slot on the same edge, so a push into
  // a full FIFO is accepted when a pop happens alongside it.
  always_comb begin
    full     = (count_q == CNT_W'(FIFO_DEPTH));
    empty    = (count_q == '0);
    do_pop   = ev.RD_EN && !empty;
    do_push  = push_req && (!full || do_pop);
    ovf_set  = push_req && full && !do_pop;
    mem_d    = mem_q;
    if (do_push) mem_d[wr_ptr_q] = push_data;
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q;
    if (do_push && !do_pop) count_d = count_q + CNT_W'(1);
    else if (!do_push && do_pop) count_d = count_q - CNT_W'(1);
    key_press_d = do_push && !push_data[8];
    last_code_d = byte_good ? shift_q : last_code_q;
    err_d       = err_set | (err_q & ~CLR_ERR);
    ovf_d       = ovf_set | (ovf_q & ~CLR_ERR);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      flt_q       <= 1'b1;
      flt_cnt_q   <= '0;
      state_q     <= IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      parity_q    <= 1'b0;
      wd_cnt_q    <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      key_press_q <= 1'b0;
      last_code_q <= '0;
      err_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      flt_q       <= flt_d;
      flt_cnt_q   <= flt_cnt_d;
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      parity_q    <= parity_d;
      wd_cnt_q    <= wd_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      key_press_q <= key_press_d;
      last_code_q <= last_code_d;
      err_q       <= err_d;
      ovf_q       <= ovf_d;
    end
  end

  // Storage needs no reset: the head outputs are forced to zero while the
  // FIFO is empty, so stale contents are never visible.
  always_ff @(posedge CLK) begin
    mem_q <= mem_d;
  end

  assign head         = mem_q[rd_ptr_q];
  assign ev.CODE      = empty ? 8'h00 : head[7:0];
  assign ev.BREAK     = empty ? 1'b0 : head[8];
  assign ev.EXTENDED  = empty ? 1'b0 : head[9];
  assign ev.EMPTY     = empty;
  assign ev.FULL      = full;
  assign ev.COUNT     = count_q;
  assign ev.KEY_PRESS = key_press_q;
  assign LAST_CODE    = last_code_q;
  assign ERR          = err_q;
  assign OVERFLOW     = ovf_q;
endmodule

// File: doc/ps2_keyboard_fifo.md
# ps2_keyboard_fifo

Parametrised PS/2 keyboard receiver with a glitch filter, a frame watchdog, decoding of the make/break/extended prefixes, and a show-ahead event FIFO. It replaces the single-codeword keyboard path: scan codes are buffered, so the ARM-side game logic can drain key events at its own rate without losing them. It also drives the last received code for the seven-segment and LED display path.

## Interface
- FIFO_DEPTH, 8: event FIFO entries; a power of two, at least 2.
- FILTER_LEN, 8: consecutive equal synchronised samples needed before the filtered PS2_CLK changes level.
- TIMEOUT_CYCLES, 50000: CLK cycles without a falling PS2 clock edge before a partial frame is discarded.

- CLK  in  1  system clock; every flop is clocked on its rising edge.
- RST  in  1  synchronous, active-high reset.
- PS2_CLK  in  1  keyboard clock; asynchronous.
- PS2_DATA  in  1  keyboard data; asynchronous.
- RD_EN  in  1  pops the FIFO head when EMPTY=0.
- CLR_ERR  in  1  clears ERR and OVERFLOW.
- CODE  out  8  scan code at the FIFO head.
- EXTENDED  out  1  the head event was prefixed by E0.
- BREAK  out  1  the head event was prefixed by F0 (key release).
- EMPTY  out  1  FIFO is empty; CODE, EXTENDED and BREAK are valid only when EMPTY=0.
- FULL  out  1  FIFO holds FIFO_DEPTH entries.
- COUNT  out  $clog2(FIFO_DEPTH)+1  number of stored entries.
- KEY_PRESS  out  1  one-cycle pulse on every push with BREAK=0.
- LAST_CODE  out  8  last accepted data byte, including prefix bytes; feeds the seven-segment/LED path.
- ERR  out  1  sticky flag: parity, start-bit or stop-bit error.
- OVERFLOW  out  1  sticky flag: a push was dropped because the FIFO was full.

## Operation
- Input conditioning: each of PS2_CLK and PS2_DATA passes through a 2-flop synchroniser. The synchronised clock then goes through the FILTER_LEN glitch filter. A falling edge of the filtered clock produces a one-cycle sample strobe.
- Frame receiver states:
  - IDLE: on a strobe with data=0, go to DATA. On a strobe with data=1, set ERR and stay in IDLE.
  - DATA: shift in 8 bits LSB first, then go to PARITY.
  - PARITY: store the parity bit, then go to STOP.
  - STOP: the byte is good only if the total count of ones over data and parity is odd and the stop bit is 1. Otherwise set ERR and drop the byte. Return to IDLE in both cases.
- Watchdog: outside IDLE, a counter runs and is cleared on every strobe. When it reaches TIMEOUT_CYCLES, the receiver returns to IDLE and the partial frame is dropped silently; ERR is not set.
- Decoder, for each good byte (see Configuration): E0 sets the extended flag, F0 sets the break flag, and any other byte pushes {EXTENDED, BREAK, CODE} and clears both flags.
- FIFO:
  - 10-bit entries, show-ahead: the head entry is always present on the outputs.
  - A pop happens when RD_EN=1 and EMPTY=0. RD_EN while empty is ignored.
  - A push while FULL without a pop is dropped and sets OVERFLOW.
  - Push and pop in the same cycle while FULL: both happen and COUNT is unchanged.
  - Push and pop in the same cycle while empty: the push is kept and the pop is ignored.
  - Pointers are $clog2(FIFO_DEPTH) bits and wrap naturally.
- Sticky flags: CLR_ERR clears ERR and OVERFLOW. If a new error and CLR_ERR occur in the same cycle, the flag stays set.
- Reset values: EMPTY=1. FULL, COUNT, CODE, EXTENDED, BREAK, KEY_PRESS, LAST_CODE, ERR and OVERFLOW are all 0. The receiver is in IDLE, the decoder flags are clear and the filter output is 1.
- Reset mid-frame discards the partial frame and all FIFO contents.

## Timing
- Strobe latency: the strobe fires 2 (synchroniser) + FILTER_LEN cycles after a clean PS2_CLK fall.
- Push: the push register updates on the cycle after the stop-bit strobe. EMPTY falls, COUNT increments and KEY_PRESS pulses on that same edge. LAST_CODE updates on that same edge.
- Pop: on the edge where RD_EN is sampled, the head outputs advance to the next entry and COUNT decrements.
- Glitches shorter than FILTER_LEN cycles on PS2_CLK produce no strobe.

## Configuration
- PS2_BREAK_DECODE_EN defined: prefix decoding is enabled as described in Operation.
- PS2_BREAK_DECODE_EN undefined:
  - Every good byte, including E0 and F0, is pushed with EXTENDED=0 and BREAK=0.
  - KEY_PRESS pulses on every push.
  - The decoder flag registers are absent.

## Test plan
- Single frame 0x1C with correct parity, macro defined: one entry with CODE=0x1C, EXTENDED=0, BREAK=0. KEY_PRESS pulses once, LAST_CODE=0x1C and COUNT=1.
- Byte sequence E0, F0, 75: exactly one entry with CODE=0x75, EXTENDED=1, BREAK=1. No KEY_PRESS pulse and LAST_CODE=0x75. With the macro undefined, the same sequence gives three entries E0, F0, 75.
- Frame 0x1C with inverted parity bit: no push, ERR=1. After a CLR_ERR pulse, ERR=0 and a following good frame is received correctly.
- FIFO_DEPTH+1 good frames (0x01 onward) with no reads: FULL=1, OVERFLOW=1, COUNT=FIFO_DEPTH. Draining with RD_EN returns 0x01 through FIFO_DEPTH in order, then EMPTY=1.
- Start bit plus 4 data bits, then the clock held high for TIMEOUT_CYCLES: receiver back in IDLE, no push and ERR=0. The next frame 0x2A is received as 0x2A.
- Repeated 3-cycle low glitches on PS2_CLK with FILTER_LEN=8: no strobes and no state change. RST asserted mid-frame: all outputs return to their reset values and the next frame decodes cleanly.
